pong_engine: RTL and testbench
==============================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 SHALL have parameter PAD_MIN, default 5, lowest legal paddle top row.
REQ-002 SHALL have parameter PAD_MAX, default 58, highest legal paddle top row.
REQ-003 SHALL have parameter WIN_SCORE, default 7, score that ends the game (range 1..7).
REQ-004 SHALL have parameter SERVE_TICKS, default 32, ticks the ball is held at centre before play.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port tick, input, 1, one-cycle frame-advance strobe.
REQ-008 SHALL have port start, input, 1, level; begins or restarts a game.
REQ-009 SHALL have ports p1_up, p1_dn, p2_up, p2_dn, input, 1 each, paddle move requests.
REQ-010 SHALL have ports bx and by, output, 6 each, ball column and row on the 64x64 matrix.
REQ-011 SHALL have ports p1y and p2y, output, 6 each, paddle top rows; paddle spans py..py+5; P1 in columns 0-1, P2 in columns 62-63.
REQ-012 SHALL have ports sc1 and sc2, output, 3 each, player scores.
REQ-013 SHALL have ports point_p1 and point_p2, output, 1 each, one-cycle pulse when that player scores.
REQ-014 SHALL have port game_over, output, 1, high while in state OVER.

Function
REQ-015 SHALL implement the states IDLE, SERVE, PLAY and OVER, with all outputs registered.
REQ-016 SHALL update the game only on a clk edge with tick=1; with tick=0 every register holds, except that point pulses drop and start is still sampled.
REQ-017 IDLE: on start=1, SHALL go to SERVE and load the serve counter with SERVE_TICKS.
REQ-018 SERVE: ball SHALL be held at (31,31); each tick decrements the counter; the tick that sees counter==1 SHALL enter PLAY.
REQ-019 PLAY and SERVE paddles, per tick: up only -> py-1; down only -> py+1; both or neither -> hold.
REQ-020 Paddle result SHALL be clamped to [PAD_MIN, PAD_MAX]; registers never leave that range.
REQ-021 IDLE and OVER: paddles SHALL be frozen.
REQ-022 Ball direction SHALL be held as dx and dy in {-1,+1}; reset gives dx=+1, dy=+1.
REQ-023 PLAY vertical move, per tick: if by==63 with dy=+1 -> by=62, dy=-1; if by==0 with dy=-1 -> by=1, dy=+1; otherwise by+=dy.
REQ-024 PLAY horizontal move, per tick: if bx==2 with dx=-1 and p1y<=by<=p1y+5 -> bx=3, dx=+1 (P1 hit).
REQ-025 If bx==2 with dx=-1 and no P1 hit, P2 SHALL score.
REQ-026 If bx==61 with dx=+1 and p2y<=by<=p2y+5 -> bx=60, dx=-1 (P2 hit).
REQ-027 If bx==61 with dx=+1 and no P2 hit, P1 SHALL score.
REQ-028 Otherwise the ball SHALL move bx+=dx.
REQ-029 Collision checks SHALL use the by, p1y and p2y values held before this tick (pre-update).
REQ-030 A vertical bounce and a paddle hit on the same tick SHALL both apply.
REQ-031 On a score: increment the scorer's score; pulse point_px for one cycle.
REQ-032 On a score, the ball SHALL go to (31,31) with dy=+1 and dx pointing toward the player who lost the point.
REQ-033 After a score: new score==WIN_SCORE -> OVER; otherwise SERVE with the counter reloaded.
REQ-034 Scores SHALL saturate at 7 and never wrap.
REQ-035 OVER: game_over=1; ball held at (31,31).
REQ-036 OVER with start=1: SHALL clear both scores, set paddles to 29 and dx=+1, then enter SERVE.
REQ-037 start SHALL be ignored in SERVE and PLAY.

Reset
REQ-038 rst=1 SHALL immediately force state=IDLE, bx=31, by=31, p1y=p2y=29, sc1=sc2=0, dx=dy=+1.
REQ-039 rst=1 SHALL also force point_p1=point_p2=0, game_over=0 and serve counter=0.
REQ-040 Reset asserted mid-PLAY or mid-SERVE SHALL abandon the game with no score change.
REQ-041 After release, the block SHALL stay in IDLE until start=1.

Verification
REQ-042 Reset, start, then 32 ticks -> PLAY entered; next tick bx=32, by=32.
REQ-043 p1_up held for 40 ticks from p1y=29 -> p1y stops at 5; p1_up and p1_dn together -> p1y unchanged.
REQ-044 Ball at by=63, dy=+1, bx=40 -> next tick by=62, bx=41, dy=-1, no score.
REQ-045 bx=2, dx=-1, by=30, p1y=27 -> bx=3, dx=+1; same with p1y=40 -> point_p2 pulse, sc2+1, ball (31,31), dx=-1, SERVE.
REQ-046 sc1=6 and P1 scores -> sc1=7, game_over=1; start -> sc1=sc2=0, SERVE.
REQ-047 rst pulsed mid-PLAY with sc2=3 -> outputs equal reset values within the same cycle; state IDLE.

Source files
------------

// File: rtl/pong_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pong_engine                                                |
// | Description : Two-player Pong game engine on a 64x64 grid. Owns the game |
// |               state machine (IDLE/SERVE/PLAY/OVER), ball motion, paddle  |
// |               motion, collision detection and scoring. Game time only    |
// |               advances on clock edges where tick is high.                |
// | Ports       : clk, rst        - clock, asynchronous active-high reset    |
// |               tick            - one-cycle frame-advance strobe           |
// |               start           - level, begins / restarts a game          |
// |               p1_up/p1_dn     - player 1 paddle requests                 |
// |               p2_up/p2_dn     - player 2 paddle requests                 |
// |               bx, by          - ball column / row                        |
// |               p1y, p2y        - paddle top rows (paddle is 6 rows tall)  |
// |               sc1, sc2        - player scores                            |
// |               point_p1/_p2    - one-cycle pulse when a player scores     |
// |               game_over       - high while the game is finished          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pong_engine #(
  parameter int PAD_MIN     = 5,
  parameter int PAD_MAX     = 58,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [5:0] bx,
  output logic [5:0] by,
  output logic [5:0] p1y,
  output logic [5:0] p2y,
  output logic [2:0] sc1,
  output logic [2:0] sc2,
  output logic       point_p1,
  output logic       point_p2,
  output logic       game_over
);

  localparam int CW = (SERVE_TICKS < 1) ? 1 : $clog2(SERVE_TICKS + 1);

  localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_TICKS);
  localparam logic [5:0]    PMIN       = 6'(PAD_MIN);
  localparam logic [5:0]    PMAX       = 6'(PAD_MAX);
  localparam logic [5:0]    MID        = 6'd31;
  localparam logic [5:0]    HOME       = 6'd29;
  localparam logic [2:0]    WIN        = 3'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    bx_q, bx_d, by_q, by_d;
  logic [5:0]    p1y_q, p1y_d, p2y_q, p2y_d;
  logic [2:0]    sc1_q, sc1_d, sc2_q, sc2_d;
  logic          dxn_q, dxn_d;   // 1 = ball moving toward column 0
  logic          dyn_q, dyn_d;   // 1 = ball moving toward row 0
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pt1_q, pt1_d, pt2_q, pt2_d, over_q, over_d;

  logic          p1_hit, p2_hit;
  logic          scored;
  logic [2:0]    sc_new;

  // One-row paddle step, clamped to the legal range. Both or neither
  // request leaves the paddle where it is.
  function automatic logic [5:0] paddle_next(input logic [5:0] p,
                                             input logic       up,
                                             input logic       dn);
    logic [5:0] r;
    r = p;
    if (up && !dn) begin
      r = (p <= PMIN) ? PMIN : p - 6'd1;
    end else if (dn && !up) begin
      r = (p >= PMAX) ? PMAX : p + 6'd1;
    end
    return r;
  endfunction

  // Hit windows use the pre-tick ball row and paddle rows; the 7-bit sum
  // keeps py+5 from wrapping near the bottom of the field.
  assign p1_hit = (by_q >= p1y_q) && ({1'b0, by_q} <= ({1'b0, p1y_q} + 7'd5));
  assign p2_hit = (by_q >= p2y_q) && ({1'b0, by_q} <= ({1'b0, p2y_q} + 7'd5));

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    p1y_d   = p1y_q;
    p2y_d   = p2y_q;
    sc1_d   = sc1_q;
    sc2_d   = sc2_q;
    dxn_d   = dxn_q;
    dyn_d   = dyn_q;
    cnt_d   = cnt_q;
    pt1_d   = 1'b0;
    pt2_d   = 1'b0;
    scored  = 1'b0;
    sc_new  = 3'd0;

    case (state_q)
      IDLE: begin
        // start acts on any edge here, tick is not required
        if (start) begin
          state_d = SERVE;
          cnt_d   = SERVE_LOAD;
        end
      end

      OVER: begin
        if (start) begin
          sc1_d   = 3'd0;
          sc2_d   = 3'd0;
          p1y_d   = HOME;
          p2y_d   = HOME;
          dxn_d   = 1'b0;
          state_d = SERVE;
          cnt_d   = SERVE_LOAD;
        end
      end

      SERVE: begin
        if (tick) begin
          p1y_d = paddle_next(p1y_q, p1_up, p1_dn);
          p2y_d = paddle_next(p2y_q, p2_up, p2_dn);
          bx_d  = MID;
          by_d  = MID;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
          if (cnt_q <= CW'(1)) begin
            state_d = PLAY;
          end
        end
      end

      PLAY: begin
        if (tick) begin
          p1y_d = paddle_next(p1y_q, p1_up, p1_dn);
          p2y_d = paddle_next(p2y_q, p2_up, p2_dn);

          // vertical motion with wall bounce
          if (by_q == 6'd63 && !dyn_q) begin
            by_d  = 6'd62;
            dyn_d = 1'b1;
          end else if (by_q == 6'd0 && dyn_q) begin
            by_d  = 6'd1;
            dyn_d = 1'b0;
          end else begin
            by_d = dyn_q ? by_q - 6'd1 : by_q + 6'd1;
          end

          // horizontal motion, paddle hits and misses
          if (bx_q == 6'd2 && dxn_q) begin
            if (p1_hit) begin
              bx_d  = 6'd3;
              dxn_d = 1'b0;
            end else begin
              scored = 1'b1;
              sc_new = (sc2_q == 3'd7) ? 3'd7 : sc2_q + 3'd1;
              sc2_d  = sc_new;
              pt2_d  = 1'b1;
              dxn_d  = 1'b1;   // serve toward P1, who lost the point
            end
          end else if (bx_q == 6'd61 && !dxn_q) begin
            if (p2_hit) begin
              bx_d  = 6'd60;
              dxn_d = 1'b1;
            end else begin
              scored = 1'b1;
              sc_new = (sc1_q == 3'd7) ? 3'd7 : sc1_q + 3'd1;
              sc1_d  = sc_new;
              pt1_d  = 1'b1;
              dxn_d  = 1'b0;   // serve toward P2, who lost the point
            end
          end else begin
            bx_d = dxn_q ? bx_q - 6'd1 : bx_q + 6'd1;
          end

          // a point overrides the ball motion computed above
          if (scored) begin
            bx_d    = MID;
            by_d    = MID;
            dyn_d   = 1'b0;
            cnt_d   = SERVE_LOAD;
            state_d = (sc_new == WIN) ? OVER : SERVE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bx_q    <= MID;
      by_q    <= MID;
      p1y_q   <= HOME;
      p2y_q   <= HOME;
      sc1_q   <= 3'd0;
      sc2_q   <= 3'd0;
      dxn_q   <= 1'b0;
      dyn_q   <= 1'b0;
      cnt_q   <= '0;
      pt1_q   <= 1'b0;
      pt2_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      p1y_q   <= p1y_d;
      p2y_q   <= p2y_d;
      sc1_q   <= sc1_d;
      sc2_q   <= sc2_d;
      dxn_q   <= dxn_d;
      dyn_q   <= dyn_d;
      cnt_q   <= cnt_d;
      pt1_q   <= pt1_d;
      pt2_q   <= pt2_d;
      over_q  <= over_d;
    end
  end

  assign bx        = bx_q;
  assign by        = by_q;
  assign p1y       = p1y_q;
  assign p2y       = p2y_q;
  assign sc1       = sc1_q;
  assign sc2       = sc2_q;
  assign point_p1  = pt1_q;
  assign point_p2  = pt2_q;
  assign game_over = over_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pong_engine                                             |
// | Description : Self-checking bench for pong_engine. Directed scenarios    |
// |               plus randomized play compared against a rule-level model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pong_engine;

  localparam int PAD_MIN     = 5;
  localparam int PAD_MAX     = 58;
  localparam int WIN_SCORE   = 7;
  localparam int SERVE_TICKS = 32;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_OVER  = 3;

  localparam logic [32:0] RST_VEC = {6'd31, 6'd31, 6'd29, 6'd29, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst, tick, start, p1_up, p1_dn, p2_up, p2_dn;
  logic [5:0] bx, by, p1y, p2y;
  logic [2:0] sc1, sc2;
  logic       point_p1, point_p2, game_over;

  wire [32:0] obs = {bx, by, p1y, p2y, sc1, sc2, point_p1, point_p2, game_over};

  pong_engine #(
    .PAD_MIN(PAD_MIN), .PAD_MAX(PAD_MAX), .WIN_SCORE(WIN_SCORE), .SERVE_TICKS(SERVE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .bx(bx), .by(by), .p1y(p1y), .p2y(p2y), .sc1(sc1), .sc2(sc2),
    .point_p1(point_p1), .point_p2(point_p2), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural game model ----------------
  int m_mode, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_dx, m_dy, m_cnt;
  bit m_pt1, m_pt2;

  function automatic int pad_move(input int p, input bit u, input bit d);
    int r;
    r = p;
    if (u && !d) r = p - 1;
    if (d && !u) r = p + 1;
    if (r < PAD_MIN) r = PAD_MIN;
    if (r > PAD_MAX) r = PAD_MAX;
    return r;
  endfunction

  function automatic logic [32:0] exp_vec();
    return {6'(m_bx), 6'(m_by), 6'(m_p1), 6'(m_p2), 3'(m_s1), 3'(m_s2),
            m_pt1, m_pt2, (m_mode == M_OVER)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_bx = 31; m_by = 31; m_p1 = 29; m_p2 = 29;
    m_s1 = 0; m_s2 = 0; m_dx = 1; m_dy = 1; m_cnt = 0; m_pt1 = 0; m_pt2 = 0;
  endtask

  task automatic model_step(input bit tk, input bit st, input bit u1, input bit d1,
                            input bit u2, input bit d2);
    int oby, op1, op2, winner;
    m_pt1 = 0; m_pt2 = 0; winner = 0;
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (st) begin
        if (m_mode == M_OVER) begin
          m_s1 = 0; m_s2 = 0; m_p1 = 29; m_p2 = 29; m_dx = 1;
        end
        m_mode = M_SERVE; m_cnt = SERVE_TICKS;
      end
    end else if (tk) begin
      oby = m_by; op1 = m_p1; op2 = m_p2;
      m_p1 = pad_move(m_p1, u1, d1);
      m_p2 = pad_move(m_p2, u2, d2);
      if (m_mode == M_SERVE) begin
        m_bx = 31; m_by = 31;
        if (m_cnt == 1) m_mode = M_PLAY;
        m_cnt = m_cnt - 1;
      end else begin
        if (oby == 63 && m_dy == 1) begin m_by = 62; m_dy = -1; end
        else if (oby == 0 && m_dy == -1) begin m_by = 1; m_dy = 1; end
        else m_by = oby + m_dy;
        if (m_bx == 2 && m_dx == -1) begin
          if (oby >= op1 && oby <= op1 + 5) begin m_bx = 3; m_dx = 1; end
          else winner = 2;
        end else if (m_bx == 61 && m_dx == 1) begin
          if (oby >= op2 && oby <= op2 + 5) begin m_bx = 60; m_dx = -1; end
          else winner = 1;
        end else begin
          m_bx = m_bx + m_dx;
        end
        if (winner != 0) begin
          if (winner == 1) begin
            m_s1 = (m_s1 < 7) ? m_s1 + 1 : 7; m_pt1 = 1; m_dx = 1;
          end else begin
            m_s2 = (m_s2 < 7) ? m_s2 + 1 : 7; m_pt2 = 1; m_dx = -1;
          end
          m_bx = 31; m_by = 31; m_dy = 1; m_cnt = SERVE_TICKS;
          m_mode = (((winner == 1) ? m_s1 : m_s2) == WIN_SCORE) ? M_OVER : M_SERVE;
        end
      end
    end
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic step(input bit tk, input bit st, input bit u1, input bit d1,
                      input bit u2, input bit d2);
    @(negedge clk);
    tick = tk; start = st; p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    @(posedge clk);
    model_step(tk, st, u1, d1, u2, d2);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 0; start = 0; p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Randomized play: each player follows the ball with probability trk%.
  task automatic run_play(input int ncyc, input int trk1, input int trk2,
                          input int stop_s2, input bit stop_over, output bit reached);
    bit tk, st, u1, d1, u2, d2;
    int tgt;
    reached = 0;
    for (int i = 0; i < ncyc; i++) begin
      tk  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 9) == 0);
      tgt = m_by - 2;
      if (int'($urandom_range(0, 99)) < trk1) begin u1 = (m_p1 > tgt); d1 = (m_p1 < tgt); end
      else begin u1 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1)); end
      if (int'($urandom_range(0, 99)) < trk2) begin u2 = (m_p2 > tgt); d2 = (m_p2 < tgt); end
      else begin u2 = 1'($urandom_range(0, 1)); d2 = 1'($urandom_range(0, 1)); end
      if (stop_over) st = 0;
      step(tk, st, u1, d1, u2, d2);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL play cyc=%0d got=%h want=%h (bx,by,p1y,p2y,sc1,sc2,pt1,pt2,go)",
                 i, obs, exp_vec());
      end
      if (stop_over && m_mode == M_OVER) begin reached = 1; break; end
      if (stop_s2 >= 0 && m_s2 == stop_s2) begin reached = 1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; tick = 0; start = 0; p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== RST_VEC) begin
      bad++; $display("FAIL reset_values got=%h want=%h", obs, RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)));
      total++;
      if (obs !== RST_VEC) begin
        bad++; $display("FAIL idle_hold got=%h want=%h", obs, RST_VEC);
      end
    end
  endtask

  task automatic test_serve();
    step(0, 1, 0, 0, 0, 0);
    total++;
    if (obs !== exp_vec() || game_over !== 1'b0) begin
      bad++; $display("FAIL serve_start got=%h want=%h", obs, exp_vec());
    end
    for (int i = 0; i < 31; i++) step(1, 0, 0, 0, 0, 0);
    total++;
    if ({bx, by} !== {6'd31, 6'd31}) begin
      bad++; $display("FAIL serve_hold31 got=%0d,%0d want=31,31", bx, by);
    end
    step(1, 0, 0, 0, 0, 0);
    total++;
    if ({bx, by} !== {6'd31, 6'd31}) begin
      bad++; $display("FAIL serve_hold32 got=%0d,%0d want=31,31", bx, by);
    end
    step(1, 0, 0, 0, 0, 0);
    total++;
    if ({bx, by} !== {6'd32, 6'd32}) begin
      bad++; $display("FAIL first_move got=%0d,%0d want=32,32", bx, by);
    end
    step(0, 1, 1, 0, 0, 1);
    total++;
    if ({bx, by, p1y, p2y} !== {6'd32, 6'd32, 6'd29, 6'd29}) begin
      bad++; $display("FAIL tick_low_hold got=%0d,%0d,%0d,%0d want=32,32,29,29", bx, by, p1y, p2y);
    end
  endtask

  task automatic test_paddle();
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 1, 0, 0, 1);
      if (i == 9) begin
        total++;
        if ({p1y, p2y} !== {6'd19, 6'd39}) begin
          bad++; $display("FAIL paddle_mid got=%0d,%0d want=19,39", p1y, p2y);
        end
      end
    end
    total++;
    if ({p1y, p2y, bx, by} !== {6'd5, 6'd58, 6'd39, 6'd39}) begin
      bad++; $display("FAIL paddle_clamp got=%0d,%0d,%0d,%0d want=5,58,39,39", p1y, p2y, bx, by);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 0);
    total++;
    if ({p1y, p2y, bx, by} !== {6'd5, 6'd58, 6'd42, 6'd42}) begin
      bad++; $display("FAIL paddle_both got=%0d,%0d,%0d,%0d want=5,58,42,42", p1y, p2y, bx, by);
    end
  endtask

  task automatic test_random();
    bit r;
    do_reset();
    run_play(3000, 60, 60, -1, 0, r);
  endtask

  task automatic test_game_over();
    bit r;
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    run_play(20000, 100, 0, -1, 1, r);
    total++;
    if (!r || game_over !== 1'b1 || (sc1 !== 3'd7 && sc2 !== 3'd7)) begin
      bad++; $display("FAIL game_over got=%b sc=%0d,%0d want=1 with a score of 7", game_over, sc1, sc2);
    end
    step(0, 1, 0, 0, 0, 0);
    total++;
    if ({sc1, sc2, p1y, p2y, game_over} !== {3'd0, 3'd0, 6'd29, 6'd29, 1'b0}) begin
      bad++; $display("FAIL restart got=%0d,%0d,%0d,%0d,%b want=0,0,29,29,0", sc1, sc2, p1y, p2y, game_over);
    end
    for (int i = 0; i < 33; i++) step(1, 0, 0, 0, 0, 0);
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL restart_play got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    bit r;
    int n;
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    run_play(5000, 30, 100, 3, 0, r);
    n = 0;
    while (m_mode != M_PLAY && n < 100) begin
      step(1, 0, 0, 0, 0, 0);
      n++;
    end
    step(1, 0, 0, 0, 0, 0);
    total++;
    if (!r || m_mode != M_PLAY || sc2 !== 3'd3) begin
      bad++; $display("FAIL reach_play_sc2 got=%0d want=3 in play", sc2);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== RST_VEC) begin
      bad++; $display("FAIL async_reset got=%h want=%h", obs, RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 1, 0);
      total++;
      if (obs !== exp_vec() || obs !== RST_VEC) begin
        bad++; $display("FAIL post_reset_idle got=%h want=%h", obs, RST_VEC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddle();
    test_random();
    test_game_over();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
